// File: rtl/i2c_slave_regs.sv
`timescale 1ns/1ps
// I2C target answering SLAVE_ADDR; exposes an 8-bit register-pointer read/write bus.
// Optional SCL/SDA glitch filter is enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_regs #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_wr_en_o,
    output logic       reg_rd_en_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
    } state_e;

    if (FILTER_LEN < 1) begin : g_filter_len_check
        $error("FILTER_LEN must be at least 1");
    end

    // Synchronizers reset to the idle-bus level so reset release creates no false edges.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_f, sda_f;
    logic       scl_q, sda_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

    logic [CntW-1:0] scl_cnt_q, sda_cnt_q;
    logic            scl_filt_q, sda_filt_q;

    // Filtered value flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            if (scl_sync_q[1] == scl_filt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CntMax) begin
                scl_filt_q <= scl_sync_q[1];
                scl_cnt_q  <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 1'b1;
            end
            if (sda_sync_q[1] == sda_filt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CntMax) begin
                sda_filt_q <= sda_sync_q[1];
                sda_cnt_q  <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 1'b1;
            end
        end
    end

    assign scl_f = scl_filt_q;
    assign sda_f = sda_filt_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       rw_q, rw_d;
    logic       first_byte_q, first_byte_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_en_q, wr_en_d;
    logic       rd_en_q, rd_en_d;
    logic       rd_req_q, rd_req_d;
    logic       rd_load_q, rd_load_d;
    logic       busy_q, busy_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            first_byte_q <= 1'b0;
            sda_oe_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_load_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            first_byte_q <= first_byte_d;
            sda_oe_q     <= sda_oe_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            rd_req_q     <= rd_req_d;
            rd_load_q    <= rd_load_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        first_byte_d = first_byte_q;
        sda_oe_d     = sda_oe_q;
        busy_d       = busy_q;
        wr_en_d      = 1'b0;
        rd_req_d     = 1'b0;
        rd_en_d      = rd_req_q;
        rd_load_d    = rd_en_q;
        // Pointer advances the cycle after a write strobe; read data lands one cycle after rd_en.
        if (wr_en_q) begin
            addr_d = addr_q + 8'd1;
        end
        if (rd_load_q) begin
            shift_d = reg_rdata_i;
        end

        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_d  = StAddrAck;
                            rw_d     = shift_q[0];
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_rise && rw_q) begin
                        rd_en_d = 1'b1;
                    end else if (scl_fall) begin
                        if (rw_q) begin
                            state_d  = StRdByte;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d      = StWrByte;
                            first_byte_d = 1'b1;
                            sda_oe_d     = 1'b0;
                        end
                    end
                end
                StWrByte: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d   = StWrAck;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b1;
                        if (first_byte_q) begin
                            addr_d       = shift_q;
                            first_byte_d = 1'b0;
                        end else begin
                            wdata_d = shift_q;
                            wr_en_d = 1'b1;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        state_d  = StWrByte;
                        sda_oe_d = 1'b0;
                    end
                end
                StRdByte: begin
                    if (scl_fall) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        if (bit_cnt_q == 4'd7) begin
                            state_d   = StRdAck;
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            sda_oe_d  = ~shift_q[6];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            addr_d   = addr_q + 8'd1;
                            rd_req_d = 1'b1;
                        end else begin
                            state_d = StIgnore;
                        end
                    end else if (scl_fall) begin
                        state_d  = StRdByte;
                        sda_oe_d = ~shift_q[7];
                    end
                end
                StIgnore: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_en_o = wr_en_q;
    assign reg_rd_en_o = rd_en_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
`timescale 1ns/1ps
// Directed bench for i2c_slave_regs: bit-banged I2C master plus a small register-file model.
module tb_i2c_slave_regs;

    localparam int Q = 20;  // clk cycles per SCL phase

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe, wr_en, rd_en, busy;
    logic [7:0] reg_addr, wdata;
    logic [7:0] rdata = 8'h00;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [256];
    logic [7:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         oe_cycles = 0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regs #(
        .SLAVE_ADDR(7'h50),
        .FILTER_LEN(4)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .reg_addr_o (reg_addr),
        .reg_wdata_o(wdata),
        .reg_wr_en_o(wr_en),
        .reg_rd_en_o(rd_en),
        .reg_rdata_i(rdata),
        .busy_o     (busy)
    );

    // Register file model: read data valid one cycle after rd_en; strobes logged.
    always @(posedge clk) begin
        if (rd_en) begin
            rdata  <= mem[reg_addr];
            rd_cnt <= rd_cnt + 1;
        end
        if (wr_en) begin
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt[3:0]] <= reg_addr;
                wr_data_log[wr_cnt[3:0]] <= wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (sda_oe) oe_cycles <= oe_cycles + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_clk(Q);
            scl_m = 1'b1; wait_clk(Q);
            scl_m = 1'b0; wait_clk(2);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q / 2);
        ack = sda_bus; wait_clk(Q / 2);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] data);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_clk(Q);
            scl_m = 1'b1; wait_clk(Q / 2);
            data[i] = sda_bus; wait_clk(Q / 2);
            scl_m = 1'b0; wait_clk(2);
        end
        sda_m = master_ack; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        scl_m = 1'b0; wait_clk(2);
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         oe_before;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'h7E;

        // Reset state
        wait_clk(4);
        check("rst_sda_oe", 8'(sda_oe), 8'h00);
        rst_n = 1'b1;
        wait_clk(4);
        check("rst_sda_oe_rel", 8'(sda_oe), 8'h00);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_wdata", wdata, 8'h00);
        check("rst_wr_en", 8'(wr_en), 8'h00);
        check("rst_rd_en", 8'(rd_en), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);

        // Write 0x5A, 0xC3 starting at pointer 0x10
        bus_start();
        check("wr_busy_start", 8'(busy), 8'h01);
        write_byte(8'hA0, ack); check("wr_ack_addr", 8'(ack), 8'h00);
        write_byte(8'h10, ack); check("wr_ack_ptr", 8'(ack), 8'h00);
        write_byte(8'h5A, ack); check("wr_ack_d0", 8'(ack), 8'h00);
        write_byte(8'hC3, ack); check("wr_ack_d1", 8'(ack), 8'h00);
        bus_stop();
        check("wr_strobes", 8'(wr_cnt), 8'd2);
        check("wr0_addr", wr_addr_log[0], 8'h10);
        check("wr0_data", wr_data_log[0], 8'h5A);
        check("wr1_addr", wr_addr_log[1], 8'h11);
        check("wr1_data", wr_data_log[1], 8'hC3);
        check("wr_final_ptr", reg_addr, 8'h12);
        check("wr_busy_stop", 8'(busy), 8'h00);

        // Random read: pointer 0x20, repeated START, two bytes
        bus_start();
        write_byte(8'hA0, ack); check("rd_ack_waddr", 8'(ack), 8'h00);
        write_byte(8'h20, ack); check("rd_ack_ptr", 8'(ack), 8'h00);
        bus_start();
        write_byte(8'hA1, ack); check("rd_ack_raddr", 8'(ack), 8'h00);
        read_byte(1'b0, rd); check("rd_byte0", rd, 8'h3C);
        read_byte(1'b1, rd); check("rd_byte1", rd, 8'h7E);
        wait_clk(Q);
        check("rd_sda_released", 8'(sda_oe), 8'h00);
        check("rd_busy_before_stop", 8'(busy), 8'h01);
        bus_stop();
        check("rd_ptr", reg_addr, 8'h21);
        check("rd_requests", 8'(rd_cnt), 8'd2);
        check("rd_no_writes", 8'(wr_cnt), 8'd2);

        // Wrong address: never ACKs, no strobes
        oe_before = oe_cycles;
        bus_start();
        write_byte(8'hA2, ack); check("bad_nack_addr", 8'(ack), 8'h01);
        write_byte(8'h55, ack); check("bad_nack_data", 8'(ack), 8'h01);
        check("bad_busy", 8'(busy), 8'h01);
        bus_stop();
        check("bad_oe_never", 8'(oe_cycles - oe_before), 8'h00);
        check("bad_no_wr", 8'(wr_cnt), 8'd2);
        check("bad_no_rd", 8'(rd_cnt), 8'd2);
        check("bad_busy_stop", 8'(busy), 8'h00);

        // Pointer wrap 0xFF -> 0x00
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'hFF, ack);
        write_byte(8'h11, ack);
        write_byte(8'h22, ack); check("wrap_ack", 8'(ack), 8'h00);
        bus_stop();
        check("wrap_strobes", 8'(wr_cnt), 8'd4);
        check("wrap0_addr", wr_addr_log[2], 8'hFF);
        check("wrap0_data", wr_data_log[2], 8'h11);
        check("wrap1_addr", wr_addr_log[3], 8'h00);
        check("wrap1_data", wr_data_log[3], 8'h22);
        check("wrap_ptr", reg_addr, 8'h01);

        // STOP after 4 bits of a data byte
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h30, ack);
        send_bits(8'hF0, 4);
        bus_stop();
        check("midstop_no_wr", 8'(wr_cnt), 8'd4);
        check("midstop_oe", 8'(sda_oe), 8'h00);
        check("midstop_busy", 8'(busy), 8'h00);
        check("midstop_ptr", reg_addr, 8'h30);

        // Reset asserted while the address ACK is being driven
        bus_start();
        send_bits(8'hA0, 8);
        sda_m = 1'b1; wait_clk(Q / 2);
        check("rstack_oe_on", 8'(sda_oe), 8'h01);
        rst_n = 1'b0;
        #1;
        check("rstack_oe_off", 8'(sda_oe), 8'h00);
        check("rstack_ptr", reg_addr, 8'h00);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        check("rstack_busy", 8'(busy), 8'h00);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // 2-cycle SDA glitch while SCL high must not look like START
        sda_m = 1'b0; wait_clk(2);
        sda_m = 1'b1; wait_clk(Q);
        check("glitch_busy", 8'(busy), 8'h00);
        bus_start();
        check("glitch_real_start", 8'(busy), 8'h01);
        bus_stop();
        check("glitch_real_stop", 8'(busy), 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
